hdmi_timing_gen: RTL and testbench
==================================

Name: hdmi_timing_gen

Overview:
- Video timing generator for the ADV7513 pixel path, downstream of the DDR3 frame-buffer read port.
- Generates hsync, vsync and de for the HDMI transmitter, and issues the per-pixel read request to the frame buffer ahead of the active video.
- Aligns the returned RGB565 pixels with de.
- Detects read underflow and overflow, and starts or stops only on frame boundaries.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clk cycles)
H_SYNC, 40, hsync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width
V_BP, 20, vertical back porch
HS_POL, 1, asserted level of hsync
VS_POL, 1, asserted level of vsync
RD_LAT, 2, fixed cycles from rd_req to rgb_din_vld; legal range 1..H_SYNC+H_BP
UNDERFLOW_RGB, 16'hF800, colour driven on an underflowed pixel

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run request (HDMI config done)
err_clr  in  1  clears the sticky error flags
rgb_din  in  16  RGB565 pixel from the frame buffer
rgb_din_vld  in  1  rgb_din valid
rd_req  out  1  one-pixel read request to the frame buffer
hdmi_tx_rgb  out  16  RGB565 pixel out
hdmi_tx_de  out  1  data enable
hdmi_tx_hsync  out  1  line sync
hdmi_tx_vsync  out  1  frame sync
frame_start  out  1  1-cycle pulse coincident with the first output cycle of a frame
underflow  out  1  sticky flag: de pixel with no data
overflow  out  1  sticky flag: data with no pixel slot

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Derived values: H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- Counter regions: hsync region h<H_SYNC; vsync region v<V_SYNC.
- Active region: H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE, and the same form on v.
- Reset values:
  - State=IDLE, h=v=0.
  - rd_req=0, hdmi_tx_de=0, hdmi_tx_rgb=0, frame_start=0, underflow=0, overflow=0.
  - hdmi_tx_hsync=~HS_POL, hdmi_tx_vsync=~VS_POL.
- FSM IDLE/RUN:
  - IDLE holds h=v=0. enable=1 moves to RUN; the counter is at (0,0) in the first RUN cycle.
  - In RUN, h increments each cycle and wraps at H_TOTAL-1. v increments on h wrap and wraps at V_TOTAL-1.
  - At counter (H_TOTAL-1, V_TOTAL-1): enable=0 moves to IDLE, else RUN continues.
  - enable is not sampled anywhere else. Dropping enable mid-frame lets the frame complete.
- Pipeline, for counter value (h,v) at cycle t:
  - t+1: rd_req = active(h+RD_LAT, v). No line wrap is possible given the RD_LAT limit. de_d1 = active(h,v) (internal).
  - t+1: the pixel is accepted if rgb_din_vld=1.
  - t+2: hdmi_tx_de, hdmi_tx_hsync, hdmi_tx_vsync and hdmi_tx_rgb for (h,v) are driven.
  - t+2: frame_start=1 when (h,v)=(0,0) in RUN.
- Net timing: rd_req leads hdmi_tx_de by RD_LAT+1 cycles. The rd_req count per frame equals H_ACTIVE*V_ACTIVE.
- Pixel select at t+2, by the values of de_d1 and vld at t+1:
  - de_d1=1, vld=1: hdmi_tx_rgb=rgb_din.
  - de_d1=1, vld=0: hdmi_tx_rgb=UNDERFLOW_RGB, set underflow.
  - de_d1=0, vld=1: data discarded, hdmi_tx_rgb=0, set overflow.
  - de_d1=0, vld=0: hdmi_tx_rgb=0.
- Flags are sticky until err_clr=1. If set and clear occur in the same cycle, set wins.
- After entering IDLE, the pipeline drains: rd_req is 0 from the next cycle, and the outputs return to inactive levels within 2 cycles.
- Asserting rst at any point returns to the reset values immediately. No partial frame resumes; the next run starts at (0,0).

Test Plan:
Common bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=3 (H_TOTAL=15); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2 (V_TOTAL=8); RD_LAT=2; polarities 1. The frame-buffer model returns an incrementing rgb_din exactly 2 cycles after each rd_req.
1. Reset and idle: rst=1, then rst=0 with enable=0 for 50 cycles -> all outputs stay at their reset values: hsync=0, vsync=0, de=0, rd_req=0, rgb=0.
2. Frame timing: enable=1 -> line period 15 cycles; hsync high 2 cycles per line; vsync high 15 cycles per frame; 8 de cycles per active line; 32 de cycles per frame; frame period 120 cycles; frame_start pulses once every 120 cycles.
3. Alignment: in every line, rd_req rises exactly 3 cycles before de rises. hdmi_tx_rgb over the frame carries values 0..31 in order. underflow=0 and overflow=0 at frame end.
4. Underflow: the model suppresses the 5th rgb_din_vld -> that de cycle outputs 16'hF800 and underflow goes to 1 and stays 1. Pulsing err_clr clears it to 0.
5. Overflow: inject rgb_din_vld=1 during horizontal blanking -> overflow=1; de and rgb are unaffected (rgb=0 in blanking). Asserting err_clr together with a new overflow event in the same cycle leaves overflow=1.
6. Enable drop: deassert enable at v=4 -> the frame still completes with 32 de cycles, then IDLE with no further frame_start. Re-asserting enable restarts at (0,0) and frame_start appears 2 cycles later.

Source files
------------

// File: rtl/hdmi_timing_gen_if.sv
// Signal bundle between the timing generator, the frame-buffer read port and
// the HDMI transmitter. master = generator side, slave = its environment.
interface hdmi_timing_gen_if;
  logic        enable;
  logic        err_clr;
  logic [15:0] rgb_din;
  logic        rgb_din_vld;
  logic        rd_req;
  logic [15:0] hdmi_tx_rgb;
  logic        hdmi_tx_de;
  logic        hdmi_tx_hsync;
  logic        hdmi_tx_vsync;
  logic        frame_start;
  logic        underflow;
  logic        overflow;

  modport master (
    input  enable, err_clr, rgb_din, rgb_din_vld,
    output rd_req, hdmi_tx_rgb, hdmi_tx_de, hdmi_tx_hsync, hdmi_tx_vsync,
           frame_start, underflow, overflow
  );

  modport slave (
    output enable, err_clr, rgb_din, rgb_din_vld,
    input  rd_req, hdmi_tx_rgb, hdmi_tx_de, hdmi_tx_hsync, hdmi_tx_vsync,
           frame_start, underflow, overflow
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: h/v counters, frame-buffer read request ahead of
// active video, RGB565 alignment with de, and sticky underflow/overflow flags.
module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_FP          = 110,
  parameter int unsigned H_SYNC        = 40,
  parameter int unsigned H_BP          = 220,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_FP          = 5,
  parameter int unsigned V_SYNC        = 5,
  parameter int unsigned V_BP          = 20,
  parameter bit          HS_POL        = 1'b1,
  parameter bit          VS_POL        = 1'b1,
  parameter int unsigned RD_LAT        = 2,
  parameter logic [15:0] UNDERFLOW_RGB = 16'hF800
) (
  input logic              clk,
  input logic              rst,
  hdmi_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned H_ACT_S = H_SYNC + H_BP;
  localparam int unsigned H_ACT_E = H_ACT_S + H_ACTIVE;
  localparam int unsigned V_ACT_S = V_SYNC + V_BP;
  localparam int unsigned V_ACT_E = V_ACT_S + V_ACTIVE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_de_d1;
  logic          r_hs_d1;
  logic          r_vs_d1;
  logic          r_fs_d1;

  logic w_run;
  logic w_h_last;
  logic w_v_last;
  logic w_h_act;
  logic w_v_act;
  logic w_rd_h_act;

  always_comb begin
    w_run      = (r_state == RUN);
    w_h_last   = (r_h == HW'(H_TOTAL - 1));
    w_v_last   = (r_v == VW'(V_TOTAL - 1));
    w_h_act    = (32'(r_h) >= H_ACT_S) && (32'(r_h) < H_ACT_E);
    w_v_act    = (32'(r_v) >= V_ACT_S) && (32'(r_v) < V_ACT_E);
    // RD_LAT <= H_SYNC+H_BP keeps the look-ahead inside the current line
    w_rd_h_act = (32'(r_h) + RD_LAT >= H_ACT_S) && (32'(r_h) + RD_LAT < H_ACT_E);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_h <= '0;
          r_v <= '0;
          if (bus.enable) r_state <= RUN;
        end
        RUN: begin
          if (w_h_last) begin
            r_h <= '0;
            if (w_v_last) begin
              r_v <= '0;
              if (!bus.enable) r_state <= IDLE;
            end else begin
              r_v <= r_v + VW'(1);
            end
          end else begin
            r_h <= r_h + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de_d1           <= 1'b0;
      r_hs_d1           <= 1'b0;
      r_vs_d1           <= 1'b0;
      r_fs_d1           <= 1'b0;
      bus.rd_req        <= 1'b0;
      bus.hdmi_tx_de    <= 1'b0;
      bus.hdmi_tx_hsync <= ~HS_POL;
      bus.hdmi_tx_vsync <= ~VS_POL;
      bus.hdmi_tx_rgb   <= '0;
      bus.frame_start   <= 1'b0;
      bus.underflow     <= 1'b0;
      bus.overflow      <= 1'b0;
    end else begin
      bus.rd_req <= w_run && w_rd_h_act && w_v_act;
      r_de_d1    <= w_run && w_h_act && w_v_act;
      r_hs_d1    <= w_run && (32'(r_h) < H_SYNC);
      r_vs_d1    <= w_run && (32'(r_v) < V_SYNC);
      r_fs_d1    <= w_run && (r_h == '0) && (r_v == '0);

      bus.hdmi_tx_de    <= r_de_d1;
      bus.hdmi_tx_hsync <= r_hs_d1 ? HS_POL : ~HS_POL;
      bus.hdmi_tx_vsync <= r_vs_d1 ? VS_POL : ~VS_POL;
      bus.frame_start   <= r_fs_d1;

      if (r_de_d1) bus.hdmi_tx_rgb <= bus.rgb_din_vld ? bus.rgb_din : UNDERFLOW_RGB;
      else         bus.hdmi_tx_rgb <= '0;

      // a new event in the same cycle as err_clr keeps the flag set
      bus.underflow <= (r_de_d1 && !bus.rgb_din_vld) || (bus.underflow && !bus.err_clr);
      bus.overflow  <= (!r_de_d1 && bus.rgb_din_vld) || (bus.overflow && !bus.err_clr);
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a 15x8 raster: frame-position model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hdmi_timing_gen;
  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdmi_timing_gen_if bus ();

  hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(2), .UNDERFLOW_RGB(16'hF800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // p = linear position in the frame (-1 when not running); 5<=h<13, 3<=v<7 active
  function automatic bit act(input int p, input int hoff);
    int h;
    int v;
    if (p < 0) return 1'b0;
    h = p % HT + hoff;
    v = p / HT;
    return (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
  endfunction

  // ---------------- reference model (positions of the last two cycles) ----------
  int          m_p0 = -1;
  int          m_p1 = -1;
  int          m_np;
  logic        m_de1;
  logic        e_rd = 0, e_de = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_un = 0, e_ov = 0;
  logic [15:0] e_rgb = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_p0 = -1; m_p1 = -1;
      e_rd = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_un = 0; e_ov = 0;
      e_rgb = '0;
    end else begin
      m_de1 = act(m_p1, 0);
      e_de  = m_de1;
      e_hs  = (m_p1 >= 0) && ((m_p1 % HT) < 2);
      e_vs  = (m_p1 >= 0) && ((m_p1 / HT) < 1);
      e_fs  = (m_p1 == 0);
      e_rgb = m_de1 ? (bus.rgb_din_vld ? bus.rgb_din : 16'hF800) : 16'h0000;
      e_un  = (m_de1 && !bus.rgb_din_vld) || (e_un && !bus.err_clr);
      e_ov  = (!m_de1 && bus.rgb_din_vld) || (e_ov && !bus.err_clr);
      e_rd  = act(m_p0, 2);
      if (m_p0 < 0 || m_p0 == FT - 1) m_np = bus.enable ? 0 : -1;
      else                            m_np = m_p0 + 1;
      m_p1 = m_p0;
      m_p0 = m_np;
    end
  end

  // ---------------- frame buffer + error injection (drives at negedge) ----------
  bit          rq0 = 0, rq1 = 0, r_ret;
  int          ret_cnt = 0;
  int          sup_at = -1;
  logic [15:0] pix = '0;
  bit          inj_req = 0, inj_clr = 0, clr_req = 0;
  int          inj_done = 0;

  initial forever begin
    @(negedge clk);
    bus.rgb_din_vld = 1'b0;
    bus.err_clr     = 1'b0;
    if (rst) begin
      rq0 = 0; rq1 = 0; r_ret = 0;
    end else begin
      r_ret = rq1; rq1 = rq0; rq0 = bus.rd_req;
    end
    if (r_ret) begin
      ret_cnt++;
      if (ret_cnt != sup_at) begin
        bus.rgb_din_vld = 1'b1;
        bus.rgb_din     = pix;
        pix++;
      end
    end
    if (inj_req && bus.hdmi_tx_hsync) begin
      bus.rgb_din_vld = 1'b1;
      bus.rgb_din     = 16'hABCD;
      inj_req = 0;
      inj_done++;
      if (inj_clr) begin bus.err_clr = 1'b1; inj_clr = 0; end
    end
    if (clr_req) begin bus.err_clr = 1'b1; clr_req = 0; end
  end

  // ---------------- per-cycle compare and statistics ------------------------------
  int ncyc = 0;
  int fs_total = 0, last_fs = 0, fs_period = 0;
  int f_de = 0, f_hs = 0, f_vs = 0, f_rd = 0;
  int last_de = 0, last_hs = 0, last_vs = 0, last_rd = 0;
  int last_rd_rise = 0, lead_n = 0, lead_bad = 0;
  int last_hs_rise = 0, hs_period = 0;
  int f800_n = 0, blank_bad = 0;
  bit p_rd = 0, p_de = 0, p_hs = 0;
  logic [15:0] q_rgb[$];

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!rst) begin
      chk("rd_req", 32'(bus.rd_req),        32'(e_rd));
      chk("de",     32'(bus.hdmi_tx_de),    32'(e_de));
      chk("hsync",  32'(bus.hdmi_tx_hsync), 32'(e_hs));
      chk("vsync",  32'(bus.hdmi_tx_vsync), 32'(e_vs));
      chk("fstart", 32'(bus.frame_start),   32'(e_fs));
      chk("rgb",    32'(bus.hdmi_tx_rgb),   32'(e_rgb));
      chk("uflow",  32'(bus.underflow),     32'(e_un));
      chk("oflow",  32'(bus.overflow),      32'(e_ov));

      if (bus.frame_start) begin
        if (fs_total > 0) begin
          last_de = f_de; last_hs = f_hs; last_vs = f_vs; last_rd = f_rd;
          fs_period = ncyc - last_fs;
        end
        f_de = 0; f_hs = 0; f_vs = 0; f_rd = 0;
        last_fs = ncyc;
        fs_total++;
      end
      if (bus.hdmi_tx_de)    f_de++;
      if (bus.hdmi_tx_hsync) f_hs++;
      if (bus.hdmi_tx_vsync) f_vs++;
      if (bus.rd_req)        f_rd++;
      if (bus.hdmi_tx_de) q_rgb.push_back(bus.hdmi_tx_rgb);
      if (bus.hdmi_tx_de && bus.hdmi_tx_rgb == 16'hF800) f800_n++;
      if (!bus.hdmi_tx_de && bus.hdmi_tx_rgb != 16'h0000) blank_bad++;
      if (bus.rd_req && !p_rd) last_rd_rise = ncyc;
      if (bus.hdmi_tx_de && !p_de) begin
        lead_n++;
        if (ncyc - last_rd_rise != 3) lead_bad++;
      end
      if (bus.hdmi_tx_hsync && !p_hs) begin
        hs_period    = ncyc - last_hs_rise;
        last_hs_rise = ncyc;
      end
      p_rd = bus.rd_req; p_de = bus.hdmi_tx_de; p_hs = bus.hdmi_tx_hsync;
    end
  end

  // ---------------- directed scenarios -------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_literal(input string pfx);
    chk({pfx, "_rd_req"}, 32'(bus.rd_req),        32'd0);
    chk({pfx, "_de"},     32'(bus.hdmi_tx_de),    32'd0);
    chk({pfx, "_hsync"},  32'(bus.hdmi_tx_hsync), 32'd0);
    chk({pfx, "_vsync"},  32'(bus.hdmi_tx_vsync), 32'd0);
    chk({pfx, "_rgb"},    32'(bus.hdmi_tx_rgb),   32'd0);
    chk({pfx, "_fstart"}, 32'(bus.frame_start),   32'd0);
    chk({pfx, "_uflow"},  32'(bus.underflow),     32'd0);
    chk({pfx, "_oflow"},  32'(bus.overflow),      32'd0);
  endtask

  int t, bad, fsn, en_cyc, rel_cyc, want;

  initial begin
    bus.enable = 1'b0; bus.err_clr = 1'b0; bus.rgb_din = '0; bus.rgb_din_vld = 1'b0;
    rst = 1'b1;
    step(3);
    chk_reset_literal("in_rst");
    rst = 1'b0;
    step(50);
    chk_reset_literal("idle50");

    // frame timing and alignment
    q_rgb.delete(); lead_n = 0; lead_bad = 0; fs_total = 0;
    bus.enable = 1'b1;
    t = 0;
    while (fs_total < 2 && t < 400) begin step(1); t++; end
    chk("two_frames_timeout", 32'(t < 400), 32'd1);
    chk("frame_de_cnt",    32'(last_de),   32'd32);
    chk("frame_hs_cnt",    32'(last_hs),   32'd16);
    chk("frame_vs_cnt",    32'(last_vs),   32'd15);
    chk("frame_rd_cnt",    32'(last_rd),   32'd32);
    chk("frame_period",    32'(fs_period), 32'd120);
    chk("line_period",     32'(hs_period), 32'd15);
    chk("de_rises_frame1", 32'(lead_n),    32'd4);
    chk("rd_de_lead_bad",  32'(lead_bad),  32'd0);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (q_rgb.size() <= i || q_rgb[i] != 16'(i)) bad++;
    chk("rgb_seq_bad", 32'(bad), 32'd0);
    chk("frame_end_uflow", 32'(bus.underflow), 32'd0);
    chk("frame_end_oflow", 32'(bus.overflow),  32'd0);

    // underflow: drop the 5th returned pixel
    f800_n = 0;
    sup_at = ret_cnt + 5;
    t = 0;
    while (f800_n == 0 && t < 300) begin step(1); t++; end
    chk("underflow_timeout", 32'(t < 300), 32'd1);
    step(20);
    chk("underflow_sticky", 32'(bus.underflow), 32'd1);
    chk("f800_once",        32'(f800_n),        32'd1);
    clr_req = 1;
    step(3);
    chk("underflow_cleared", 32'(bus.underflow), 32'd0);
    chk("no_overflow_yet",   32'(bus.overflow),  32'd0);

    // overflow: stray data in horizontal blanking
    want = inj_done + 1;
    inj_req = 1;
    t = 0;
    while (inj_done < want && t < 50) begin step(1); t++; end
    chk("inject1_timeout", 32'(t < 50), 32'd1);
    step(2);
    chk("overflow_set",      32'(bus.overflow),  32'd1);
    chk("overflow_no_uflow", 32'(bus.underflow), 32'd0);
    chk("blank_rgb_nonzero", 32'(blank_bad),     32'd0);
    want = inj_done + 1;
    inj_clr = 1;
    inj_req = 1;
    t = 0;
    while (inj_done < want && t < 50) begin step(1); t++; end
    chk("inject2_timeout", 32'(t < 50), 32'd1);
    step(2);
    chk("overflow_set_wins", 32'(bus.overflow), 32'd1);
    clr_req = 1;
    step(3);
    chk("overflow_cleared", 32'(bus.overflow), 32'd0);

    // enable drop mid-frame (around v=4): the frame must finish, then idle
    fsn = fs_total;
    t = 0;
    while (fs_total == fsn && t < 200) begin step(1); t++; end
    chk("drop_sync_timeout", 32'(t < 200), 32'd1);
    step(60);
    bus.enable = 1'b0;
    fsn = fs_total;
    step(200);
    chk("drop_frame_de",   32'(f_de),          32'd32);
    chk("drop_no_fstart",  32'(fs_total),      32'(fsn));
    chk("drop_idle_rd",    32'(bus.rd_req),    32'd0);
    chk("drop_idle_de",    32'(bus.hdmi_tx_de), 32'd0);

    // re-enable: first RUN cycle follows the enable sample, frame_start 2 cycles later
    bus.enable = 1'b1;
    en_cyc = ncyc;
    t = 0;
    while (fs_total == fsn && t < 20) begin step(1); t++; end
    chk("restart_timeout",    32'(t < 20),          32'd1);
    chk("restart_fs_latency", 32'(last_fs - en_cyc), 32'd4);

    // reset in the middle of a run, then restart from (0,0)
    step(30);
    rst = 1'b1;
    #1;
    chk_reset_literal("rst_midrun");
    step(2);
    rst = 1'b0;
    rel_cyc = ncyc;
    fsn = fs_total;
    t = 0;
    while (fs_total == fsn && t < 20) begin step(1); t++; end
    chk("rst_restart_timeout", 32'(t < 20),            32'd1);
    chk("rst_restart_fs",      32'(last_fs - rel_cyc), 32'd4);
    step(20);
    bus.enable = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
